instr_encoder: RTL and testbench
================================

# instr_encoder

Encoder for the single-cycle CPU's supported MIPS subset. It is the inverse of the control decoder: it turns symbolic instruction fields into 32-bit instruction words and writes them one after another into instruction memory. The test harness or a boot loader drives it over a valid/ready handshake, and it sits in front of the instruction-memory write port.

## Interface

Parameters:
- ADDR_W, 5: word-address width. Memory depth is 2^ADDR_W words.

Ports:
- clk_i, in, 1: clock. All state changes on the rising edge.
- rst_i, in, 1: reset, asynchronous, active-low.
- clear_i, in, 1: synchronous restart of the write pointer and count to 0.
- in_valid_i, in, 1: the instruction fields are valid.
- in_ready_o, out, 1: the encoder can accept fields.
- kind_i, in, 4: mnemonic. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 BEQ, 6 BNE, 7 ADDI, 8 SLTI, 9 LUI, 10 ORI. Values 11–15 are illegal.
- rs_i, rt_i, rd_i, in, 5 each: register fields.
- imm_i, in, 16: immediate or branch offset.
- mem_we_o, out, 1: instruction-memory write strobe.
- mem_addr_o, out, ADDR_W: word address.
- mem_data_o, out, 32: encoded instruction.
- err_o, out, 1: one-cycle pulse for an illegal kind.
- full_o, out, 1: memory filled.
- count_o, out, ADDR_W+1: number of words written.

## Operation

- States:
  - IDLE: waiting for fields.
  - WRITE: presenting one write to memory.
- Acceptance:
  - A transfer occurs when in_valid_i and in_ready_o are both high on a clock edge.
  - in_ready_o = (state==IDLE) & ~full_o & ~clear_i. It is combinational.
- On transfer:
  - Fields are encoded and registered.
  - For a legal kind: go to WRITE.
  - For an illegal kind: stay in IDLE, pulse err_o for the next cycle, write nothing, leave the pointer unchanged.
- R-type encoding (kinds 0–4): {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- I-type encoding (kinds 5–10): {op, rs, rt, imm}.
  - op: BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, LUI 001111, ORI 001101.
  - For LUI the rs field is forced to 00000.
  - rd_i is ignored for all I-type kinds.
- WRITE state (exactly one cycle):
  - mem_we_o=1.
  - mem_addr_o = current pointer.
  - mem_data_o = encoded word.
  - On exit, pointer and count_o increment by 1 and the state returns to IDLE.
- Pointer and count:
  - The pointer is count_o[ADDR_W-1:0].
  - full_o = (count_o == 2^ADDR_W).
  - When the last slot is written, the pointer wraps to 0 and count_o saturates at 2^ADDR_W.
  - No further transfers are accepted until clear_i or reset.
- clear_i:
  - Takes effect at the next edge: count_o=0, pointer=0, full_o=0.
  - If asserted during WRITE, the write still completes at the old address, but clear wins over the increment: count_o becomes 0, not old+1.
  - An err_o pulse already scheduled is unaffected.

## Timing

- Reset (rst_i low) forces immediately, without waiting for a clock edge:
  - state=IDLE.
  - mem_we_o=0, mem_addr_o=0, mem_data_o=0.
  - err_o=0, full_o=0, count_o=0.
  - in_ready_o=1 whenever clear_i=0.
- Reset during WRITE aborts the write: mem_we_o drops asynchronously and the pointer is not incremented.
- Latency:
  - A transfer at edge N gives mem_we_o high during cycle N+1.
  - count_o is updated at edge N+2.
- Throughput: one instruction every 2 cycles. in_ready_o is low during WRITE.
- err_o: a transfer at edge N with an illegal kind gives err_o=1 during cycle N+1 only. in_ready_o stays high, so back-to-back illegal transfers produce consecutive pulses.
- Outputs while idle:
  - mem_we_o=0 in every cycle other than WRITE.
  - mem_addr_o and mem_data_o hold their last values.
- No combinational path from in_valid_i to any output.

## Test plan

- Reset, then ADDI with rs=0, rt=8, imm=0x0005: one cycle later mem_we_o=1, addr=0, data=0x20080005; then count_o=1.
- ADD with rd=10, rs=8, rt=9, then LUI with rs=7, rt=1, imm=0x1234, driven back-to-back with in_valid_i held high:
  - Writes 0x01095020 at addr 0 and 0x3C011234 at addr 1.
  - in_ready_o is low in each WRITE cycle.
- BEQ with rs=1, rt=2, imm=0xFFFF, then kind=13: 0x1022FFFF is written; then err_o pulses for 1 cycle, no write occurs, and count_o stays at 1.
- ADDR_W=2, four ORI writes:
  - full_o=1 and count_o=4 after the 4th write.
  - in_ready_o=0 and further in_valid_i is ignored.
  - After clear_i, count_o=0 and the next write goes to addr 0.
- clear_i asserted in the WRITE cycle of the third instruction: the write lands at addr 2, then count_o=0, and the next instruction is written at addr 0.
- rst_i pulled low mid-WRITE: mem_we_o=0 immediately, count_o=0, and after release the next instruction is written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS-subset fields into 32-bit words and streams them
// into instruction memory, one word per two-cycle valid/ready transfer.
module instr_encoder #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              err_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_SLT  = 4'd4;
    localparam logic [3:0] K_BEQ  = 4'd5;
    localparam logic [3:0] K_BNE  = 4'd6;
    localparam logic [3:0] K_ADDI = 4'd7;
    localparam logic [3:0] K_SLTI = 4'd8;
    localparam logic [3:0] K_LUI  = 4'd9;
    localparam logic [3:0] K_ORI  = 4'd10;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            state_q, state_d;
    logic              we_d, err_d, full_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       data_d;
    logic [CNT_W-1:0]  count_d;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              xfer;

    assign in_ready_o = (state_q == S_IDLE) & ~full_o & ~clear_i;
    assign xfer       = in_valid_i & in_ready_o;

    // Field-to-word encoding; kinds above ORI are flagged illegal.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (kind_i)
            K_ADD:   enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100000};
            K_SUB:   enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100010};
            K_AND:   enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100100};
            K_OR:    enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100101};
            K_SLT:   enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b101010};
            K_BEQ:   enc_word = {6'b000100, rs_i, rt_i, imm_i};
            K_BNE:   enc_word = {6'b000101, rs_i, rt_i, imm_i};
            K_ADDI:  enc_word = {6'b001000, rs_i, rt_i, imm_i};
            K_SLTI:  enc_word = {6'b001010, rs_i, rt_i, imm_i};
            K_LUI:   enc_word = {6'b001111, 5'b00000, rt_i, imm_i};
            K_ORI:   enc_word = {6'b001101, rs_i, rt_i, imm_i};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        addr_d  = mem_addr_o;
        data_d  = mem_data_o;
        count_d = count_o;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (enc_legal) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = count_o[ADDR_W-1:0];
                        data_d  = enc_word;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                count_d = count_o + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Clear overrides the post-write increment; the write itself still lands.
        if (clear_i) begin
            count_d = '0;
        end
        full_d = (count_d == DEPTH);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            err_o      <= 1'b0;
            full_o     <= 1'b0;
            count_o    <= '0;
        end else begin
            state_q    <= state_d;
            mem_we_o   <= we_d;
            mem_addr_o <= addr_d;
            mem_data_o <= data_d;
            err_o      <= err_d;
            full_o     <= full_d;
            count_o    <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a driver queues expected writes and
// error pulses, a negedge monitor pops and compares them as they appear.
module tb_instr_encoder;

    localparam int unsigned AW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [3:0]    kind_i = '0;
    logic [4:0]    rs_i = '0;
    logic [4:0]    rt_i = '0;
    logic [4:0]    rd_i = '0;
    logic [15:0]   imm_i = '0;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          err_o;
    logic          full_o;
    logic [AW:0]   count_o;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .kind_i     (kind_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .imm_i      (imm_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .err_o      (err_o),
        .full_o     (full_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          is_err;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_total = 0;
    int            n_pass  = 0;
    logic [AW-1:0] exp_ptr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    // Monitor: every write strobe or error pulse must match the queue head.
    always @(negedge clk_i) begin
        if (rst_i && (mem_we_o || err_o)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: we=%0b err=%0b addr=%0d data=0x%08h, required nothing",
                         mem_we_o, err_o, mem_addr_o, mem_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    chk("err_pulse", {31'd0, err_o}, 32'd1);
                    chk("err_no_write", {31'd0, mem_we_o}, 32'd0);
                end else begin
                    chk("write_addr", 32'(mem_addr_o), 32'(e.addr));
                    chk("write_data", mem_data_o, e.data);
                end
            end
        end
    end

    // Present fields and wait (bounded) for the transfer edge.
    task automatic issue(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] word);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk_i);
        kind_i = k; rs_i = rs; rt_i = rt; rd_i = rd; imm_i = imm;
        in_valid_i = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready_o) begin
                e.is_err = (k > 4'd10);
                e.addr   = e.is_err ? '0 : exp_ptr;
                e.data   = e.is_err ? '0 : word;
                if (!e.is_err) exp_ptr = exp_ptr + 1'b1;
                exp_q.push_back(e);
                @(posedge clk_i);
                done = 1'b1;
            end else begin
                @(negedge clk_i);
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL issue_timeout: in_ready_o=0 for 20 cycles, required 1");
        end
    endtask

    task automatic issue_wait(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] word);
        issue(k, rs, rt, rd, imm, word);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic do_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        exp_ptr = '0;
        @(negedge clk_i);
        clear_i = 1'b0;
    endtask

    initial begin
        // Asynchronous reset values before any clock edge
        #1;
        chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_we",    {31'd0, mem_we_o},   32'd0);
        chk("rst_addr",  32'(mem_addr_o),     32'd0);
        chk("rst_data",  mem_data_o,          32'd0);
        chk("rst_err",   {31'd0, err_o},      32'd0);
        chk("rst_full",  {31'd0, full_o},     32'd0);
        chk("rst_count", 32'(count_o),        32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ADDI $8, $0, 5
        issue_wait(4'd7, 5'd0, 5'd8, 5'd0, 16'h0005, 32'h2008_0005);
        chk("addi_count", 32'(count_o), 32'd1);

        // ADD then LUI back-to-back with valid held high
        do_clear();
        issue(4'd0, 5'd8, 5'd9, 5'd10, 16'h0000, 32'h0109_5020);
        @(negedge clk_i);
        chk("add_write_ready", {31'd0, in_ready_o}, 32'd0);
        chk("add_write_we",    {31'd0, mem_we_o},   32'd1);
        issue(4'd9, 5'd7, 5'd1, 5'd0, 16'h1234, 32'h3C01_1234);
        @(negedge clk_i);
        chk("lui_write_ready", {31'd0, in_ready_o}, 32'd0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_count", 32'(count_o), 32'd2);

        // BEQ, then illegal kinds (single and back-to-back)
        do_clear();
        issue_wait(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 32'h1022_FFFF);
        issue(4'd13, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("err_ready_high", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        chk("err_count", 32'(count_o), 32'd1);
        issue(4'd15, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0);
        issue(4'd11, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("err2_count", 32'(count_o), 32'd1);

        // Fill all four slots with ORI, then confirm further fields are refused
        do_clear();
        for (int i = 0; i < 4; i++) begin
            issue_wait(4'd10, 5'd1, 5'd2, 5'd0, 16'(i), 32'h3422_0000 | 32'(i));
        end
        chk("full_flag",  {31'd0, full_o}, 32'd1);
        chk("full_count", 32'(count_o),    32'd4);
        @(negedge clk_i);
        in_valid_i = 1'b1;
        kind_i = 4'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("full_ready", {31'd0, in_ready_o}, 32'd0);
        end
        in_valid_i = 1'b0;
        chk("full_hold_count", 32'(count_o), 32'd4);
        do_clear();
        chk("clear_count", 32'(count_o),    32'd0);
        chk("clear_full",  {31'd0, full_o}, 32'd0);
        issue_wait(4'd10, 5'd3, 5'd4, 5'd0, 16'hBEEF, 32'h3464_BEEF);

        // clear_i during the third write's WRITE cycle
        do_clear();
        issue_wait(4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h0022_1822);
        issue_wait(4'd2, 5'd4, 5'd5, 5'd6, 16'h0000, 32'h0085_3024);
        issue(4'd4, 5'd7, 5'd8, 5'd9, 16'h0000, 32'h00E8_482A);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        clear_i = 1'b1;
        exp_ptr = '0;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clear_in_write_count", 32'(count_o), 32'd0);
        issue_wait(4'd6, 5'd9, 5'd10, 5'd0, 16'h0010, 32'h152A_0010);
        chk("after_clear_count", 32'(count_o), 32'd1);

        // Reset in the middle of a WRITE aborts it
        do_clear();
        issue(4'd8, 5'd2, 5'd3, 5'd0, 16'h0007, 32'h2843_0007);
        #2;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("midrst_we",    {31'd0, mem_we_o}, 32'd0);
        chk("midrst_count", 32'(count_o),      32'd0);
        exp_q.delete();
        exp_ptr = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        issue_wait(4'd7, 5'd0, 5'd8, 5'd0, 16'h0005, 32'h2008_0005);
        chk("post_rst_count", 32'(count_o), 32'd1);

        repeat (3) @(negedge clk_i);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

endmodule
